rtc_bus_cycle: RTL and testbench

- Physical-bus engine directly downstream of the RTC sequencing FSM.
- Converts one byte-transfer request (address plus write data, or address plus read) into a timed multiplexed address/data bus cycle on the RTC pins: CS_n, RD_n, WR_n, A/D select and an 8-bit tri-stateable AD bus.
- The FSM issues one request per register access and waits for done.

---
 rtl/rtc_bus_cycle_if.sv | 54 +++++
 rtl/rtc_bus_cycle.sv | 225 ++++++++++++++++++++++
 tb/tb_rtc_bus_cycle.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_cycle_if.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_bus_cycle_if
//  Purpose  : Bundles the request/response handshake between the RTC
//             sequencing FSM and the bus-cycle engine together with the RTC
//             pin-level signals (strobes, A/D select, multiplexed AD bus).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Signals
//    req       start request (sampled by the engine only while idle)
//    rd_nwr    1 = read cycle, 0 = write cycle, captured with req
//    addr      RTC register address, captured with req
//    wdata     write data, captured with req
//    busy      transaction in flight (first phase through the done cycle)
//    done      one-cycle pulse at the end of a transaction
//    rdata     last byte read from the RTC
//    rtc_cs_n  chip select, active low
//    rtc_rd_n  read strobe, active low
//    rtc_wr_n  write strobe, active low
//    rtc_ad    0 = address phase, 1 = data phase
//    ad_out    value driven onto the AD bus
//    ad_oe     AD bus output enable (1 = drive)
//    ad_in     AD bus readback from the pad
//  Modports
//    master  requester / pad side (drives request fields and ad_in)
//    slave   bus-cycle engine
// ============================================================================
interface rtc_bus_cycle_if;
  logic       req;
  logic       rd_nwr;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       rtc_cs_n;
  logic       rtc_rd_n;
  logic       rtc_wr_n;
  logic       rtc_ad;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] ad_in;

  modport master (
    output req, rd_nwr, addr, wdata, ad_in,
    input  busy, done, rdata, rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad, ad_out, ad_oe
  );

  modport slave (
    input  req, rd_nwr, addr, wdata, ad_in,
    output busy, done, rdata, rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad, ad_out, ad_oe
  );
endinterface
`default_nettype wire

// File: rtl/rtc_bus_cycle.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_bus_cycle
//  Purpose  : Physical-bus engine for the RTC. Turns one byte-transfer
//             request into a timed multiplexed address/data bus cycle:
//             an address write phase, a chip-select gap, then a data phase
//             (write or read), followed by a one-cycle done pulse.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    T_SU   setup cycles before a strobe falls          (>= 1)
//    T_PW   strobe low-width cycles                      (>= 1)
//    T_HD   hold cycles after a strobe rises             (>= 1)
//    T_GAP  chip-select-high cycles between the phases   (>= 1)
//    CW     width of the phase counter, must hold max(T_*)
//  Ports
//    clk    system clock
//    clr    synchronous active-high reset
//    bus    rtc_bus_cycle_if.slave: request handshake and RTC pins
// ============================================================================
module rtc_bus_cycle #(
  parameter int T_SU  = 2,
  parameter int T_PW  = 10,
  parameter int T_HD  = 3,
  parameter int T_GAP = 4,
  parameter int CW    = 8
) (
  input  wire logic     clk,
  input  wire logic     clr,
  rtc_bus_cycle_if.slave bus
);

  // Terminal counter values: a phase ends when the counter reaches T_x - 1.
  localparam logic [CW-1:0] SU_LAST  = CW'(T_SU  - 1);
  localparam logic [CW-1:0] PW_LAST  = CW'(T_PW  - 1);
  localparam logic [CW-1:0] HD_LAST  = CW'(T_HD  - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(T_GAP - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_A_SETUP = 4'd1,
    S_A_PULSE = 4'd2,
    S_A_HOLD  = 4'd3,
    S_GAP     = 4'd4,
    S_D_SETUP = 4'd5,
    S_D_PULSE = 4'd6,
    S_D_HOLD  = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  // Request fields captured at acceptance.
  logic          rnw_q,   rnw_d;
  logic [7:0]    addr_q,  addr_d;
  logic [7:0]    wdata_q, wdata_d;

  // Registered outputs.
  logic          cs_n_q,   cs_n_d;
  logic          rd_n_q,   rd_n_d;
  logic          wr_n_q,   wr_n_d;
  logic          rtc_ad_q, rtc_ad_d;
  logic          ad_oe_q,  ad_oe_d;
  logic [7:0]    ad_out_q, ad_out_d;
  logic          busy_q,   busy_d;
  logic          done_q,   done_d;
  logic [7:0]    rdata_q,  rdata_d;

  // --------------------------------------------------------------------------
  // Next-state, counter and output decode.
  // Outputs are decoded from the *next* state and registered alongside it,
  // so every pin changes on the same edge the state changes and all outputs
  // come straight from flops.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    rnw_d    = rnw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          state_d = S_A_SETUP;
          rnw_d   = bus.rd_nwr;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
        end
      end
      S_A_SETUP: if (cnt_q == SU_LAST)  state_d = S_A_PULSE;
      S_A_PULSE: if (cnt_q == PW_LAST)  state_d = S_A_HOLD;
      S_A_HOLD:  if (cnt_q == HD_LAST)  state_d = S_GAP;
      S_GAP:     if (cnt_q == GAP_LAST) state_d = S_D_SETUP;
      S_D_SETUP: if (cnt_q == SU_LAST)  state_d = S_D_PULSE;
      S_D_PULSE: begin
        if (cnt_q == PW_LAST) begin
          state_d = S_D_HOLD;
          // Capture on the last low cycle of RD_n, when the RTC data has
          // had the full strobe width to settle.
          if (rnw_q) begin
            rdata_d = bus.ad_in;
          end
        end
      end
      S_D_HOLD:  if (cnt_q == HD_LAST)  state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Counter restarts on every state entry and is parked at zero in IDLE.
    if ((state_d != state_q) || (state_d == S_IDLE)) begin
      cnt_d = '0;
    end

    // Idle pin levels are the default for every state.
    cs_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    rtc_ad_d = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = 8'h00;
    busy_d   = 1'b1;
    done_d   = 1'b0;

    case (state_d)
      S_IDLE: begin
        busy_d = 1'b0;
      end
      S_A_SETUP, S_A_HOLD: begin
        cs_n_d   = 1'b0;
        rtc_ad_d = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
      end
      S_A_PULSE: begin
        // The address is always latched into the RTC with WR_n, even when
        // the transaction is a read.
        cs_n_d   = 1'b0;
        rtc_ad_d = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
        wr_n_d   = 1'b0;
      end
      S_GAP: begin
        // Chip select released, bus undriven.
      end
      S_D_SETUP, S_D_HOLD: begin
        cs_n_d = 1'b0;
        if (!rnw_d) begin
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_d;
        end
      end
      S_D_PULSE: begin
        cs_n_d = 1'b0;
        if (rnw_d) begin
          // Bus released for the whole read phase so the RTC can drive it.
          rd_n_d = 1'b0;
        end else begin
          wr_n_d   = 1'b0;
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_d;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State, counter, capture and output registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rnw_q    <= 1'b0;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      rtc_ad_q <= 1'b1;
      ad_oe_q  <= 1'b0;
      ad_out_q <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rnw_q    <= rnw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cs_n_q   <= cs_n_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      rtc_ad_q <= rtc_ad_d;
      ad_oe_q  <= ad_oe_d;
      ad_out_q <= ad_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.rtc_cs_n = cs_n_q;
  assign bus.rtc_rd_n = rd_n_q;
  assign bus.rtc_wr_n = wr_n_q;
  assign bus.rtc_ad   = rtc_ad_q;
  assign bus.ad_oe    = ad_oe_q;
  assign bus.ad_out   = ad_out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rdata    = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_cycle.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rtc_bus_cycle
//  Purpose  : Self-checking bench for rtc_bus_cycle. Two instances run side
//             by side: u0 with default timing, u1 with all timings = 1.
//             A phase-table model predicts every pin each cycle; directed
//             transactions additionally pin literal latencies and data.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rtc_bus_cycle;

  typedef struct packed {
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       rtc_ad;
    logic       ad_oe;
    logic [7:0] ad_out;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct {
    int done_rel, busy, awf, awl, dwf, dwl, rdf, rdc, oed, aval, dval, rdata;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr_v   [2];
  logic       req_v   [2];
  logic       rnw_v   [2];
  logic [7:0] addr_v  [2];
  logic [7:0] wdata_v [2];
  logic       in_mode [2];
  logic [7:0] ad_in_v [2];

  logic       cs_w [2], rd_w [2], wr_w [2], ad_w [2], oe_w [2], busy_w [2], done_w [2];
  logic [7:0] ad_out_w [2], rdata_w [2];

  rtc_bus_cycle_if bus0 ();
  rtc_bus_cycle_if bus1 ();

  assign bus0.req = req_v[0];  assign bus0.rd_nwr = rnw_v[0];
  assign bus0.addr = addr_v[0]; assign bus0.wdata = wdata_v[0];
  assign bus0.ad_in = ad_in_v[0];
  assign bus1.req = req_v[1];  assign bus1.rd_nwr = rnw_v[1];
  assign bus1.addr = addr_v[1]; assign bus1.wdata = wdata_v[1];
  assign bus1.ad_in = ad_in_v[1];

  assign cs_w[0] = bus0.rtc_cs_n; assign rd_w[0] = bus0.rtc_rd_n; assign wr_w[0] = bus0.rtc_wr_n;
  assign ad_w[0] = bus0.rtc_ad;   assign oe_w[0] = bus0.ad_oe;    assign ad_out_w[0] = bus0.ad_out;
  assign busy_w[0] = bus0.busy;   assign done_w[0] = bus0.done;   assign rdata_w[0] = bus0.rdata;
  assign cs_w[1] = bus1.rtc_cs_n; assign rd_w[1] = bus1.rtc_rd_n; assign wr_w[1] = bus1.rtc_wr_n;
  assign ad_w[1] = bus1.rtc_ad;   assign oe_w[1] = bus1.ad_oe;    assign ad_out_w[1] = bus1.ad_out;
  assign busy_w[1] = bus1.busy;   assign done_w[1] = bus1.done;   assign rdata_w[1] = bus1.rdata;

  rtc_bus_cycle #(.T_SU(2), .T_PW(10), .T_HD(3), .T_GAP(4), .CW(8)) u_dut0 (
    .clk(clk), .clr(clr_v[0]), .bus(bus0.slave)
  );
  rtc_bus_cycle #(.T_SU(1), .T_PW(1), .T_HD(1), .T_GAP(1), .CW(8)) u_dut1 (
    .clk(clk), .clr(clr_v[1]), .bus(bus1.slave)
  );

  // --------------------------------------------------------------------------
  // RTC pad stand-in: while RD_n is low it returns 0x47 (mode 0) or
  // 0x80 + number of cycles RD_n has already been low (mode 1); 0xFF otherwise.
  // --------------------------------------------------------------------------
  int lowcnt [2];
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) lowcnt[u] <= rd_w[u] ? 0 : lowcnt[u] + 1;
  end

  function automatic logic [7:0] pad_val(input logic rd_n, input logic mode, input int lc);
    if (rd_n) return 8'hFF;
    if (mode) return 8'(8'h80 + lc);
    return 8'h47;
  endfunction

  assign ad_in_v[0] = pad_val(rd_w[0], in_mode[0], lowcnt[0]);
  assign ad_in_v[1] = pad_val(rd_w[1], in_mode[1], lowcnt[1]);

  // --------------------------------------------------------------------------
  // Checking counters
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: a transaction is a fixed sequence of phase lengths;
  // outputs follow from the offset into that sequence.
  // --------------------------------------------------------------------------
  function automatic int f_su (input int u); return (u == 0) ? 2  : 1; endfunction
  function automatic int f_pw (input int u); return (u == 0) ? 10 : 1; endfunction
  function automatic int f_hd (input int u); return (u == 0) ? 3  : 1; endfunction
  function automatic int f_gap(input int u); return (u == 0) ? 4  : 1; endfunction
  function automatic int f_len(input int u); return f_su(u) + f_pw(u) + f_hd(u); endfunction
  function automatic int f_total(input int u); return 2 * f_len(u) + f_gap(u) + 1; endfunction

  int         m_start [2] = '{-1, -1};
  logic       m_rnw   [2];
  logic [7:0] m_addr  [2];
  logic [7:0] m_wdata [2];
  logic [7:0] m_rdata [2] = '{8'h00, 8'h00};
  logic       edge_clr [2] = '{1'b1, 1'b1};

  function automatic exp_t exp_out(input int u, input int off);
    exp_t e;
    int   d;
    bit   pulse;
    e = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, rtc_ad: 1'b1, ad_oe: 1'b0,
          ad_out: 8'h00, busy: 1'b0, done: 1'b0};
    if (off < 0) return e;
    e.busy = 1'b1;
    if (off < f_len(u)) begin
      e.cs_n   = 1'b0;
      e.rtc_ad = 1'b0;
      e.ad_oe  = 1'b1;
      e.ad_out = m_addr[u];
      e.wr_n   = !(off >= f_su(u) && off < f_su(u) + f_pw(u));
    end else if (off < f_len(u) + f_gap(u)) begin
      // chip-select gap: idle pin levels while busy
    end else if (off < 2 * f_len(u) + f_gap(u)) begin
      d     = off - f_len(u) - f_gap(u);
      pulse = (d >= f_su(u) && d < f_su(u) + f_pw(u));
      e.cs_n = 1'b0;
      if (m_rnw[u]) begin
        e.rd_n = !pulse;
      end else begin
        e.wr_n   = !pulse;
        e.ad_oe  = 1'b1;
        e.ad_out = m_wdata[u];
      end
    end else begin
      e.done = 1'b1;
    end
    return e;
  endfunction

  int m_off;
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      m_off = (m_start[u] < 0) ? -1 : cyc - m_start[u];
      edge_clr[u] = clr_v[u];
      if (clr_v[u]) begin
        m_start[u] = -1;
        m_rdata[u] = 8'h00;
      end else if (m_off < 0) begin
        if (req_v[u]) begin
          m_start[u] = cyc + 1;
          m_rnw[u]   = rnw_v[u];
          m_addr[u]  = addr_v[u];
          m_wdata[u] = wdata_v[u];
        end
      end else begin
        if (m_rnw[u] && m_off == f_len(u) + f_gap(u) + f_su(u) + f_pw(u) - 1)
          m_rdata[u] = ad_in_v[u];
        if (m_off == f_total(u) - 1)
          m_start[u] = -1;
      end
    end
    cyc = cyc + 1;
  end

  // --------------------------------------------------------------------------
  // Per-cycle compare plus protocol invariants.
  // --------------------------------------------------------------------------
  int   c_off;
  exp_t c_e;
  bit   have_prev [2] = '{1'b0, 1'b0};
  logic prev_cs [2], prev_rd [2], prev_wr [2];

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      c_off = (m_start[u] < 0) ? -1 : cyc - m_start[u];
      c_e   = exp_out(u, c_off);
      chk($sformatf("u%0d cs_n", u),   int'(cs_w[u]),     int'(c_e.cs_n));
      chk($sformatf("u%0d rd_n", u),   int'(rd_w[u]),     int'(c_e.rd_n));
      chk($sformatf("u%0d wr_n", u),   int'(wr_w[u]),     int'(c_e.wr_n));
      chk($sformatf("u%0d rtc_ad", u), int'(ad_w[u]),     int'(c_e.rtc_ad));
      chk($sformatf("u%0d ad_oe", u),  int'(oe_w[u]),     int'(c_e.ad_oe));
      chk($sformatf("u%0d ad_out", u), int'(ad_out_w[u]), int'(c_e.ad_out));
      chk($sformatf("u%0d busy", u),   int'(busy_w[u]),   int'(c_e.busy));
      chk($sformatf("u%0d done", u),   int'(done_w[u]),   int'(c_e.done));
      chk($sformatf("u%0d rdata", u),  int'(rdata_w[u]),  int'(m_rdata[u]));
      chk($sformatf("u%0d rd_wr_overlap", u), int'(!rd_w[u] && !wr_w[u]), 0);
      chk($sformatf("u%0d oe_during_rd", u),  int'(oe_w[u] && !rd_w[u]), 0);
      if (have_prev[u] && !edge_clr[u] && (rd_w[u] != prev_rd[u] || wr_w[u] != prev_wr[u]))
        chk($sformatf("u%0d strobe_vs_cs", u), int'(!cs_w[u] && !prev_cs[u]), 1);
      have_prev[u] = 1'b1;
      prev_cs[u] = cs_w[u];
      prev_rd[u] = rd_w[u];
      prev_wr[u] = wr_w[u];
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  task automatic run_txn(input int u, input logic r, input logic [7:0] a,
                         input logic [7:0] w, output res_t res);
    res = '{default: 0};
    res.done_rel = -1; res.awf = -1; res.dwf = -1; res.rdf = -1;
    @(negedge clk);
    req_v[u] = 1'b1; rnw_v[u] = r; addr_v[u] = a; wdata_v[u] = w;
    for (int rel = 1; rel <= 80; rel++) begin
      @(negedge clk);
      if (rel == 1) begin
        // request fields are scrambled once accepted; the cycle must not care
        req_v[u] = 1'b0; rnw_v[u] = ~r; addr_v[u] = ~a; wdata_v[u] = ~w;
      end
      if (busy_w[u]) res.busy++;
      if (!wr_w[u]) begin
        if (!ad_w[u]) begin
          if (res.awf < 0) begin res.awf = rel; res.aval = int'(ad_out_w[u]); end
          res.awl = rel;
        end else begin
          if (res.dwf < 0) begin res.dwf = rel; res.dval = int'(ad_out_w[u]); end
          res.dwl = rel;
        end
      end
      if (!rd_w[u]) begin
        if (res.rdf < 0) res.rdf = rel;
        res.rdc++;
      end
      if (ad_w[u] && !cs_w[u] && oe_w[u]) res.oed++;
      if (done_w[u]) begin
        res.done_rel = rel;
        res.rdata = int'(rdata_w[u]);
        break;
      end
    end
    if (res.done_rel < 0) chk("txn_timeout", 0, 1);
  endtask

  task automatic clr_pulse(input int u);
    clr_v[u] = 1'b1;
    @(negedge clk);
    clr_v[u] = 1'b0;
  endtask

  task automatic chk_after_clr(input string tag, input int u);
    chk({tag, " cs_n"},  int'(cs_w[u]),    1);
    chk({tag, " rd_n"},  int'(rd_w[u]),    1);
    chk({tag, " wr_n"},  int'(wr_w[u]),    1);
    chk({tag, " ad_oe"}, int'(oe_w[u]),    0);
    chk({tag, " busy"},  int'(busy_w[u]),  0);
    chk({tag, " rdata"}, int'(rdata_w[u]), 0);
  endtask

  res_t r;
  int   done_cyc, gaps, prev_busy;

  initial begin
    for (int u = 0; u < 2; u++) begin
      clr_v[u] = 1'b1; req_v[u] = 1'b0; rnw_v[u] = 1'b0;
      addr_v[u] = 8'h00; wdata_v[u] = 8'h00; in_mode[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    clr_v[0] = 1'b0; clr_v[1] = 1'b0;
    repeat (5) @(negedge clk);
    chk_after_clr("reset", 0);

    // Write 0x59 to register 0x21
    run_txn(0, 1'b0, 8'h21, 8'h59, r);
    chk("wr done_rel", r.done_rel, 35);
    chk("wr busy_cycles", r.busy, 35);
    chk("wr addr wr_n first", r.awf, 3);
    chk("wr addr wr_n last", r.awl, 12);
    chk("wr addr value", r.aval, 8'h21);
    chk("wr data wr_n first", r.dwf, 22);
    chk("wr data wr_n last", r.dwl, 31);
    chk("wr data value", r.dval, 8'h59);
    repeat (2) @(negedge clk);

    // Read register 0x22, pad returns 0x47
    run_txn(0, 1'b1, 8'h22, 8'h00, r);
    chk("rd done_rel", r.done_rel, 35);
    chk("rd rd_n first", r.rdf, 22);
    chk("rd rd_n cycles", r.rdc, 10);
    chk("rd oe in data phase", r.oed, 0);
    chk("rd addr wr_n first", r.awf, 3);
    chk("rd rdata", r.rdata, 8'h47);
    repeat (2) @(negedge clk);

    // Write after read must leave rdata alone
    run_txn(0, 1'b0, 8'h30, 8'hA5, r);
    chk("wr2 data value", r.dval, 8'hA5);
    chk("wr2 rdata kept", int'(rdata_w[0]), 8'h47);
    repeat (2) @(negedge clk);

    // Read with a changing pad value: only the last strobe cycle is captured
    in_mode[0] = 1'b1;
    run_txn(0, 1'b1, 8'h23, 8'h00, r);
    chk("rd last-cycle sample", r.rdata, 8'h89);
    in_mode[0] = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back with req held high
    req_v[0] = 1'b1; rnw_v[0] = 1'b0; addr_v[0] = 8'h10; wdata_v[0] = 8'h3C;
    done_cyc = -1; gaps = 0; prev_busy = 0;
    for (int i = 0; i < 200 && gaps < 3; i++) begin
      @(negedge clk);
      if (done_w[0]) done_cyc = cyc;
      if (busy_w[0] && !prev_busy && done_cyc >= 0) begin
        chk("b2b restart gap", cyc - done_cyc, 2);
        gaps++;
      end
      prev_busy = int'(busy_w[0]);
    end
    chk("b2b restarts seen", gaps, 3);
    req_v[0] = 1'b0;
    for (int i = 0; i < 60 && busy_w[0]; i++) @(negedge clk);
    chk("b2b drained", int'(busy_w[0]), 0);
    repeat (2) @(negedge clk);

    // clr during address pulse (rdata currently 0x89)
    @(negedge clk);
    req_v[0] = 1'b1; rnw_v[0] = 1'b0; addr_v[0] = 8'h44; wdata_v[0] = 8'h55;
    @(negedge clk);
    req_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre-clr wr_n low", int'(wr_w[0]), 0);
    clr_pulse(0);
    chk_after_clr("clr A_PULSE", 0);
    repeat (2) @(negedge clk);

    // Reload rdata, then clr during a read strobe
    run_txn(0, 1'b1, 8'h22, 8'h00, r);
    chk("rd reload rdata", r.rdata, 8'h47);
    repeat (2) @(negedge clk);
    @(negedge clk);
    req_v[0] = 1'b1; rnw_v[0] = 1'b1; addr_v[0] = 8'h22;
    @(negedge clk);
    req_v[0] = 1'b0;
    repeat (24) @(negedge clk);
    chk("pre-clr rd_n low", int'(rd_w[0]), 0);
    clr_pulse(0);
    chk_after_clr("clr D_PULSE", 0);
    repeat (2) @(negedge clk);

    // Minimum timing instance
    run_txn(1, 1'b0, 8'h21, 8'h59, r);
    chk("fast wr done_rel", r.done_rel, 8);
    chk("fast wr addr wr_n first", r.awf, 2);
    chk("fast wr data wr_n first", r.dwf, 6);
    chk("fast wr busy_cycles", r.busy, 8);
    repeat (2) @(negedge clk);
    run_txn(1, 1'b1, 8'h22, 8'h00, r);
    chk("fast rd done_rel", r.done_rel, 8);
    chk("fast rd rd_n first", r.rdf, 6);
    chk("fast rd rd_n cycles", r.rdc, 1);
    chk("fast rd rdata", r.rdata, 8'h47);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
